// File: rtl/usr_shift_sequencer.sv
// Command sequencer driving the mode/d_in lines of a universal shift register.
// Takes one command per valid/ready handshake, plays it out as a timed run of
// load / shift / hold cycles and then pulses done.
//
// state | meaning
// IDLE  | waiting for a command, register held
// LOAD  | one parallel-load cycle with the latched data
// SHIFT | shifting, down-counter holds remaining shift cycles
// DONE  | one-cycle completion pulse, then back to IDLE
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             abort,
  output logic [1:0]       sr_mode,
  output logic [WIDTH-1:0] sr_d_in,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHL      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHR = 2'b11;

  state_t           state;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // abort in IDLE wins over cmd_valid; cmd_ready itself stays a pure register
  assign accept = cmd_valid & cmd_ready & ~abort;

  // Sequencer FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      cnt_q     <= '0;
      sr_mode   <= MODE_HOLD;
      sr_d_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          sr_mode   <= MODE_HOLD;
          busy      <= 1'b0;
          if (accept) begin
            op_q      <= cmd_op;
            cnt_q     <= cmd_cnt;
            sr_d_in   <= cmd_data;
            cmd_ready <= 1'b0;
            if (cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHR) begin
              state   <= LOAD;
              sr_mode <= MODE_LOAD;
              busy    <= 1'b1;
            end else if (cmd_cnt != '0) begin
              state   <= SHIFT;
              sr_mode <= (cmd_op == OP_SHL) ? MODE_SHL : MODE_SHR;
              busy    <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state     <= IDLE;
            sr_mode   <= MODE_HOLD;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            cnt_q     <= '0;
          end else if (op_q == OP_LOAD_SHR && cnt_q != '0) begin
            state   <= SHIFT;
            sr_mode <= MODE_SHR;
          end else begin
            state   <= DONE;
            sr_mode <= MODE_HOLD;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state     <= IDLE;
            sr_mode   <= MODE_HOLD;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            cnt_q     <= '0;
          end else if (cnt_q == CNT_W'(1)) begin
            // terminal count: this was the last shift cycle
            state   <= DONE;
            sr_mode <= MODE_HOLD;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          sr_mode   <= MODE_HOLD;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          sr_mode   <= MODE_HOLD;
          busy      <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
